// File: rtl/bw_loader_pkg.sv
// Shared types and frame geometry for the black/white frame loader.
package bw_loader_pkg;
  localparam int WORDS_PER_FRAME = 512;
  localparam int PIX_PER_WORD    = 32;
  localparam int ADDR_W          = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HANDOFF,
    ST_WAIT_ACK
  } state_e;
endpackage

// File: rtl/bw_pix_packer.sv
// Packs a 1-bit pixel stream LSB-first into 32-bit words; word_o is the word including the current pixel.
module bw_pix_packer
  import bw_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic        pix_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);
  logic [4:0]  cnt_q;
  logic [4:0]  cnt_d;
  logic [31:0] word_q;
  logic [31:0] word_d;

  // A clear restarts the word with this pixel as bit 0.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (en_i) begin
      if (clr_i) begin
        word_d    = '0;
        word_d[0] = pix_i;
        cnt_d     = 5'd1;
      end else begin
        word_d[cnt_q] = pix_i;
        cnt_d         = cnt_q + 5'd1;
      end
    end
  end

  assign word_o      = word_d;
  assign word_done_o = en_i && !clr_i && (cnt_q == 5'(PIX_PER_WORD - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_ff @(posedge clk_i) begin
    word_q <= word_d;
  end
endmodule

// File: rtl/bw_frame_loader.sv
// Streams binarized pixels into SoC word memory, then waits for the SoC to ack the frame.
// Optional BW_LOADER_STATS_EN adds frame_cnt_o / abort_cnt_o statistics counters.
module bw_frame_loader
  import bw_loader_pkg::*;
#(
  parameter logic [31:0] ACK_MASK = 32'h0000_0001,
  parameter int          WORDS    = 512
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              pix_valid_i,
  input  logic              pix_i,
  input  logic              pix_sof_i,
  output logic              pix_ready_o,
  output logic [31:0]       bw_in_o,
  output logic [ADDR_W-1:0] addr_in_o,
  output logic              bw_we_o,
  input  logic [31:0]       soc_status_i,
  output logic              frame_rdy_o
`ifdef BW_LOADER_STATS_EN
  ,
  output logic [15:0]       frame_cnt_o,
  output logic [15:0]       abort_cnt_o
`endif
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_e            state_q, state_d;
  logic              pix_ready_q, pix_ready_d;
  logic              frame_rdy_q, frame_rdy_d;
  logic [31:0]       bw_in_q;
  logic [ADDR_W-1:0] addr_in_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              bw_we_q;

  logic        accept, sof_acc, pk_en, word_done, last_word, ack;
  logic [31:0] pk_word;

  assign accept    = pix_valid_i && pix_ready_q;
  assign sof_acc   = accept && pix_sof_i;
  assign pk_en     = accept && (pix_sof_i || state_q == ST_FILL);
  assign last_word = word_done && (wr_addr_q == LAST_ADDR);
  assign ack       = (soc_status_i & ACK_MASK) != '0;

  bw_pix_packer u_packer (
    .clk_i       (clk_clk),
    .rst_ni      (reset_reset_n),
    .en_i        (pk_en),
    .clr_i       (sof_acc),
    .pix_i       (pix_i),
    .word_o      (pk_word),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d     = state_q;
    frame_rdy_d = frame_rdy_q;
    unique case (state_q)
      ST_IDLE:     if (sof_acc) state_d = ST_FILL;
      // Leave FILL on the strobe of the last word so the write completes first.
      ST_FILL:     if (bw_we_q && addr_in_q == LAST_ADDR) state_d = ST_HANDOFF;
      ST_HANDOFF: begin
        frame_rdy_d = 1'b1;
        state_d     = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: if (ack) begin
        frame_rdy_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
    // Stop accepting as soon as the final pixel is taken.
    pix_ready_d = (state_d == ST_IDLE || state_d == ST_FILL) && !last_word;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      pix_ready_q <= 1'b0;
      frame_rdy_q <= 1'b0;
      bw_in_q     <= '0;
      addr_in_q   <= '0;
      wr_addr_q   <= '0;
      bw_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_ready_q <= pix_ready_d;
      frame_rdy_q <= frame_rdy_d;
      bw_we_q     <= word_done;
      if (word_done) begin
        bw_in_q   <= pk_word;
        addr_in_q <= wr_addr_q;
      end
      if (sof_acc)        wr_addr_q <= '0;
      else if (word_done) wr_addr_q <= wr_addr_q + 1'b1;
    end
  end

`ifdef BW_LOADER_STATS_EN
  logic [15:0] frame_cnt_q, abort_cnt_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (state_d == ST_HANDOFF && state_q != ST_HANDOFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (sof_acc && state_q == ST_FILL)                  abort_cnt_q <= abort_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign abort_cnt_o = abort_cnt_q;
`endif

  assign pix_ready_o = pix_ready_q;
  assign frame_rdy_o = frame_rdy_q;
  assign bw_in_o     = bw_in_q;
  assign addr_in_o   = addr_in_q;
  assign bw_we_o     = bw_we_q;
endmodule
